viterbi_frame_ctrl: RTL and testbench

Sequencer for the rate-1/2 Viterbi decode datapath. Collects encoded symbol pairs from the channel side into a 64-bit frame. Launches the decoder core on the full frame and waits its fixed settle latency. Then returns the 32-bit decoded word to the consumer over a valid/ready handshake. Sits between the channel-symbol source and the decoder core; one frame is in flight at a time.

---
 rtl/viterbi_pkg.sv | 14 +
 rtl/viterbi_sym_packer.sv | 44 ++++
 rtl/viterbi_frame_ctrl.sv | 117 +++++++++++
 tb/tb_viterbi_frame_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared sizes and state encoding for the rate-1/2 Viterbi decode path.
package viterbi_pkg;

   localparam int unsigned FRAME_BITS = 32;
   localparam int unsigned SYM_W      = 2;
   localparam int unsigned ENC_BITS   = 2 * FRAME_BITS;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_e;

endpackage

// File: rtl/viterbi_sym_packer.sv
// Indexed frame register: symbol k lands in frame[2k+1:2k], first symbol in the LSBs.
module viterbi_sym_packer #(
   parameter int unsigned FRAME_BITS = viterbi_pkg::FRAME_BITS,
   parameter int unsigned IDX_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic                    clr,
   input  logic [1:0]              sym,
   output logic [2*FRAME_BITS-1:0] frame,
   output logic                    full
);
   import viterbi_pkg::*;

   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [2*FRAME_BITS-1:0] frame_q, frame_d;

   assign full  = (idx_q == IDX_W'(FRAME_BITS - 1));
   assign frame = frame_q;

   // The frame itself is never cleared so the decoder input stays put until overwritten.
   always_comb begin
      idx_d   = idx_q;
      frame_d = frame_q;
      if (clr) begin
         idx_d = '0;
      end else if (wr_en) begin
         frame_d[SYM_W*idx_q +: SYM_W] = sym;
         idx_d = full ? '0 : idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q   <= '0;
         frame_q <= '0;
      end else begin
         idx_q   <= idx_d;
         frame_q <= frame_d;
      end
   end

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer: packs symbol pairs, launches the decoder core, waits its latency,
// then holds the decoded word until the consumer takes it.
module viterbi_frame_ctrl #(
   parameter int unsigned FRAME_BITS = viterbi_pkg::FRAME_BITS,
   parameter int unsigned DEC_LAT    = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    sym_valid,
   input  logic [1:0]              sym_data,
   output logic                    sym_ready,
   input  logic                    flush,
   output logic [2*FRAME_BITS-1:0] dec_in,
   output logic                    dec_start,
   input  logic [FRAME_BITS-1:0]   dec_out,
   output logic                    out_valid,
   output logic [FRAME_BITS-1:0]   out_data,
   input  logic                    out_ready,
   output logic                    busy,
   output logic [15:0]             frame_cnt
);
   import viterbi_pkg::*;

   localparam logic [3:0] LastWait = 4'(DEC_LAT - 1);

   state_e                  state_q, state_d;
   logic [3:0]              wait_q, wait_d;
   logic                    dec_start_q, dec_start_d;
   logic                    out_valid_q, out_valid_d;
   logic [FRAME_BITS-1:0]   out_data_q, out_data_d;
   logic [15:0]             frame_cnt_q, frame_cnt_d;
   logic                    accept;
   logic                    last_sym;

   assign sym_ready = (state_q == FILL);
   assign busy      = (state_q == RUN) || (state_q == HOLD);
   assign accept    = sym_valid && sym_ready && !flush;

   assign dec_start = dec_start_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign frame_cnt = frame_cnt_q;

   viterbi_sym_packer #(
      .FRAME_BITS(FRAME_BITS)
   ) u_packer (
      .clk   (clk),
      .rst   (rst),
      .wr_en (accept),
      .clr   (flush),
      .sym   (sym_data),
      .frame (dec_in),
      .full  (last_sym)
   );

   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      dec_start_d = 1'b0;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      frame_cnt_d = frame_cnt_q;
      if (flush) begin
         state_d     = FILL;
         wait_d      = '0;
         out_valid_d = 1'b0;
      end else begin
         unique case (state_q)
            FILL: begin
               if (accept && last_sym) begin
                  state_d     = RUN;
                  dec_start_d = 1'b1;
                  wait_d      = '0;
               end
            end
            RUN: begin
               // RUN lasts exactly DEC_LAT cycles; dec_out is sampled in the last one.
               if (wait_q == LastWait) begin
                  out_data_d  = dec_out;
                  out_valid_d = 1'b1;
                  state_d     = HOLD;
                  wait_d      = '0;
               end else begin
                  wait_d = wait_q + 4'd1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  frame_cnt_d = frame_cnt_q + 16'd1;
                  out_valid_d = 1'b0;
                  state_d     = FILL;
               end
            end
            default: state_d = FILL;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= FILL;
         wait_q      <= '0;
         dec_start_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         dec_start_q <= dec_start_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed bench for viterbi_frame_ctrl with a fixed-latency decoder stub.
module tb_viterbi_frame_ctrl;

   localparam int unsigned FB = 32;
   localparam int unsigned DL = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        sym_valid;
   logic [1:0]  sym_data;
   logic        sym_ready;
   logic        flush;
   logic [63:0] dec_in;
   logic        dec_start;
   logic [31:0] dec_out;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;
   logic        busy;
   logic [15:0] frame_cnt;

   int n_cmp = 0;
   int n_err = 0;

   logic [3:0] stub_cnt;

   always #5 clk = ~clk;

   viterbi_frame_ctrl #(
      .FRAME_BITS(FB),
      .DEC_LAT   (DL)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sym_valid (sym_valid),
      .sym_data  (sym_data),
      .sym_ready (sym_ready),
      .flush     (flush),
      .dec_in    (dec_in),
      .dec_start (dec_start),
      .dec_out   (dec_out),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .busy      (busy),
      .frame_cnt (frame_cnt)
   );

   // Decoder stub: upper half of dec_in is presented only in the cycle DEC_LAT after launch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stub_cnt <= 4'd0;
      end else if (dec_start) begin
         stub_cnt <= 4'd1;
      end else if (stub_cnt != 4'd0) begin
         stub_cnt <= (stub_cnt == 4'(DL - 1)) ? 4'd0 : stub_cnt + 4'd1;
      end
   end
   assign dec_out = (stub_cnt == 4'(DL - 1)) ? dec_in[63:32] : 32'hDEAD_BEEF;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [63:0] frame);
      int k;
      int budget;
      k = 0;
      budget = 200;
      while (k < int'(FB) && budget > 0) begin
         sym_valid = 1'b1;
         sym_data  = frame[2*k +: 2];
         if (sym_ready) k++;
         step();
         budget--;
      end
      sym_valid = 1'b0;
      if (k < int'(FB)) check_eq("send_frame_timeout", 64'(k), 64'(FB));
   endtask

   task automatic wait_valid();
      int cycles;
      cycles = 0;
      while (!out_valid && cycles < 50) begin
         step();
         cycles++;
      end
      if (!out_valid) check_eq("wait_out_valid", 64'(out_valid), 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_sym_ready"}, 64'(sym_ready), 64'd1);
      check_eq({tag, "_busy"}, 64'(busy), 64'd0);
      check_eq({tag, "_dec_start"}, 64'(dec_start), 64'd0);
      check_eq({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check_eq({tag, "_out_data"}, 64'(out_data), 64'd0);
      check_eq({tag, "_dec_in"}, dec_in, 64'd0);
      check_eq({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
   endtask

   initial begin
      logic [63:0] frame;
      int          cyc;
      int          acc;
      logic        saw;

      rst       = 1'b1;
      sym_valid = 1'b0;
      sym_data  = 2'b00;
      flush     = 1'b0;
      out_ready = 1'b0;
      #12;
      check_reset_outputs("reset");
      rst = 1'b0;
      step();

      // 1: back-to-back symbols k[1:0], launch and capture timing
      out_ready = 1'b1;
      for (int k = 0; k < int'(FB); k++) frame[2*k +: 2] = 2'(k);
      send_frame(frame);
      check_eq("t1_dec_start", 64'(dec_start), 64'd1);
      check_eq("t1_dec_in", dec_in, 64'hE4E4E4E4_E4E4E4E4);
      check_eq("t1_busy", 64'(busy), 64'd1);
      check_eq("t1_sym_ready_run", 64'(sym_ready), 64'd0);
      step();
      check_eq("t1_dec_start_once", 64'(dec_start), 64'd0);
      check_eq("t1_valid_early2", 64'(out_valid), 64'd0);
      step();
      step();
      check_eq("t1_valid_early4", 64'(out_valid), 64'd0);
      step();
      check_eq("t1_out_valid", 64'(out_valid), 64'd1);
      check_eq("t1_out_data", 64'(out_data), 64'hE4E4E4E4);
      step();
      check_eq("t1_valid_drop", 64'(out_valid), 64'd0);
      check_eq("t1_frame_cnt", 64'(frame_cnt), 64'd1);
      check_eq("t1_sym_ready_back", 64'(sym_ready), 64'd1);

      // 2: all-ones frame, consumer stalls for 10 cycles
      out_ready = 1'b0;
      send_frame({64{1'b1}});
      wait_valid();
      for (int i = 0; i < 10; i++) begin
         check_eq("t2_hold_valid", 64'(out_valid), 64'd1);
         check_eq("t2_hold_data", 64'(out_data), 64'hFFFFFFFF);
         check_eq("t2_hold_sym_ready", 64'(sym_ready), 64'd0);
         step();
      end
      out_ready = 1'b1;
      check_eq("t2_valid_at_release", 64'(out_valid), 64'd1);
      step();
      out_ready = 1'b0;
      check_eq("t2_valid_drop", 64'(out_valid), 64'd0);
      check_eq("t2_sym_ready", 64'(sym_ready), 64'd1);
      check_eq("t2_frame_cnt", 64'(frame_cnt), 64'd2);
      check_eq("t2_dec_in_kept", dec_in, {64{1'b1}});

      // 3: sym_valid toggling; symbols offered outside FILL must be ignored
      acc = 0;
      cyc = 0;
      while (acc < int'(FB) && cyc < 200) begin
         sym_valid = cyc[0];
         sym_data  = (acc < 16) ? 2'b10 : 2'b01;
         if (sym_valid && sym_ready) acc++;
         step();
         cyc++;
      end
      check_eq("t3_accepts", 64'(acc), 64'd32);
      check_eq("t3_busy", 64'(busy), 64'd1);
      sym_valid = 1'b1;
      sym_data  = 2'b00;
      wait_valid();
      check_eq("t3_dec_in", dec_in, 64'h55555555_AAAAAAAA);
      check_eq("t3_out_data", 64'(out_data), 64'h55555555);
      sym_valid = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check_eq("t3_frame_cnt", 64'(frame_cnt), 64'd3);

      // 4a: flush in HOLD with out_ready high does not count the frame
      send_frame(64'h01234567_89ABCDEF);
      wait_valid();
      check_eq("t4_hold_data", 64'(out_data), 64'h01234567);
      flush     = 1'b1;
      out_ready = 1'b1;
      step();
      flush     = 1'b0;
      out_ready = 1'b0;
      check_eq("t4_flush_valid", 64'(out_valid), 64'd0);
      check_eq("t4_flush_cnt", 64'(frame_cnt), 64'd3);
      check_eq("t4_flush_ready", 64'(sym_ready), 64'd1);

      // 4b: flush after 17 symbols, then a fresh frame from k=0
      sym_valid = 1'b1;
      sym_data  = 2'b01;
      for (int i = 0; i < 17; i++) step();
      flush    = 1'b1;
      sym_data = 2'b10;
      step();
      flush     = 1'b0;
      sym_valid = 1'b0;
      check_eq("t4_after_flush_busy", 64'(busy), 64'd0);
      out_ready = 1'b1;
      for (int k = 0; k < int'(FB); k++) frame[2*k +: 2] = 2'(k) ^ 2'b11;
      send_frame(frame);
      check_eq("t4_dec_in", dec_in, 64'h1B1B1B1B_1B1B1B1B);
      wait_valid();
      check_eq("t4_out_data", 64'(out_data), 64'h1B1B1B1B);
      step();
      check_eq("t4_frame_cnt", 64'(frame_cnt), 64'd4);

      // 5: asynchronous reset between edges while in RUN
      send_frame(64'hA5A5A5A5_A5A5A5A5);
      step();
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("t5_async");
      @(posedge clk);
      #3;
      rst = 1'b0;
      saw = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (out_valid) saw = 1'b1;
      end
      check_eq("t5_no_valid", 64'(saw), 64'd0);
      check_eq("t5_sym_ready", 64'(sym_ready), 64'd1);

      // 6: frame counter wrap from 0xFFFF
      @(negedge clk);
      force dut.frame_cnt_q = 16'hFFFF;
      @(posedge clk);
      @(negedge clk);
      release dut.frame_cnt_q;
      step();
      check_eq("t6_preload", 64'(frame_cnt), 64'hFFFF);
      out_ready = 1'b1;
      send_frame(64'h12345678_00000000);
      wait_valid();
      check_eq("t6_out_data", 64'(out_data), 64'h12345678);
      step();
      check_eq("t6_wrap", 64'(frame_cnt), 64'h0000);
      check_eq("t6_valid_drop", 64'(out_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
